// File: rtl/alu_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Execute-stage ALU with registered result, valid/ready handshake,
//            shifts, compares and an iterative multiply/divide unit with
//            architectural HI/LO registers.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high, clears all state
//   in_valid   in   operands/op valid
//   in_ready   out  unit can accept (transfer on in_valid && in_ready)
//   op         in   4-bit operation select
//   in1, in2   in   operands (WIDTH bits)
//   out_valid  out  one-cycle result strobe
//   AluRes     out  registered result (WIDTH bits)
//   zero       out  registered (in1 - in2) == 0 of the accepted op
//   busy       out  multiply/divide iteration in progress
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] AluRes,
    output logic             zero,
    output logic             busy
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MFLO  = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MULT  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_MFHI  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Registered state
    state_t                 state_q,     state_d;
    logic [CNTW-1:0]        cnt_q,       cnt_d;
    logic [2*WIDTH-1:0]     p_q,         p_d;       // {HI-part, LO-part} work register
    logic [WIDTH-1:0]       a_q,         a_d;       // multiplicand or divisor magnitude
    logic                   is_div_q,    is_div_d;
    logic                   neg_lo_q,    neg_lo_d;  // negate product / quotient
    logic                   neg_hi_q,    neg_hi_d;  // negate remainder
    logic                   zpend_q,     zpend_d;   // zero flag waiting for mul/div result
    logic [WIDTH-1:0]       hi_q,        hi_d;
    logic [WIDTH-1:0]       lo_q,        lo_d;
    logic [WIDTH-1:0]       res_q,       res_d;
    logic                   zero_q,      zero_d;
    logic                   out_valid_q, out_valid_d;

    // Combinational helpers
    logic                   w_accept;
    logic                   w_zero;
    logic                   w_is_md;
    logic                   w_is_div;
    logic                   w_div0;
    logic                   w_signed;
    logic                   w_s1;
    logic                   w_s2;
    logic [WIDTH-1:0]       w_mag1;
    logic [WIDTH-1:0]       w_mag2;
    logic [CNTW-2:0]        w_sh;
    logic [WIDTH-1:0]       w_single;
    logic [WIDTH:0]         w_mul_sum;
    logic [WIDTH:0]         w_div_trial;
    logic [2*WIDTH-1:0]     w_step;
    logic [2*WIDTH-1:0]     w_prod_fix;
    logic [WIDTH-1:0]       w_quo_fix;
    logic [WIDTH-1:0]       w_rem_fix;
    logic [WIDTH-1:0]       w_fin_hi;
    logic [WIDTH-1:0]       w_fin_lo;

    assign in_ready  = (state_q == S_IDLE) && !reset;
    // A reset arriving in DONE must still suppress the completion strobe.
    assign out_valid = out_valid_q && !reset;
    assign AluRes    = res_q;
    assign zero      = zero_q;
    assign busy      = (state_q == S_BUSY);

    // Operand decode and single-cycle datapath
    always_comb begin
        w_accept = in_valid && in_ready;
        w_zero   = ((in1 - in2) == '0);
        w_is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        w_is_div = (op == OP_DIV) || (op == OP_DIVU);
        w_div0   = w_is_div && (in2 == '0);
        w_signed = (op == OP_MULT) || (op == OP_DIV);
        w_s1     = w_signed && in1[WIDTH-1];
        w_s2     = w_signed && in2[WIDTH-1];
        w_mag1   = w_s1 ? (~in1 + 1'b1) : in1;
        w_mag2   = w_s2 ? (~in2 + 1'b1) : in2;
        w_sh     = in2[CNTW-2:0];

        w_single = '0;
        case (op)
            OP_AND:  w_single = in1 & in2;
            OP_OR:   w_single = in1 | in2;
            OP_ADD:  w_single = in1 + in2;
            OP_XOR:  w_single = in1 ^ in2;
            OP_MFLO: w_single = lo_q;
            OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_SUB:  w_single = in1 - in2;
            OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLL:  w_single = in1 << w_sh;
            OP_SRL:  w_single = in1 >> w_sh;
            OP_SRA:  w_single = $signed(in1) >>> w_sh;
            OP_MFHI: w_single = hi_q;
            default: w_single = '0;
        endcase
    end

    // One iteration step and final sign correction
    always_comb begin
        // Shift-add: conditionally add multiplicand to the upper half, shift right.
        w_mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
        // Restoring divide: trial-subtract divisor from the left-shifted remainder.
        w_div_trial = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, a_q};
        if (is_div_q) begin
            if (w_div_trial[WIDTH])
                w_step = {p_q[2*WIDTH-2:0], 1'b0};
            else
                w_step = {w_div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
            w_step = {w_mul_sum, p_q[WIDTH-1:1]};
        end

        w_prod_fix = neg_lo_q ? (~w_step + 1'b1) : w_step;
        w_quo_fix  = neg_lo_q ? (~w_step[WIDTH-1:0] + 1'b1) : w_step[WIDTH-1:0];
        w_rem_fix  = neg_hi_q ? (~w_step[2*WIDTH-1:WIDTH] + 1'b1) : w_step[2*WIDTH-1:WIDTH];

        if (is_div_q) begin
            w_fin_hi = w_rem_fix;
            w_fin_lo = w_quo_fix;
        end else begin
            w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fin_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        a_d         = a_q;
        is_div_d    = is_div_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        zpend_d     = zpend_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_d       = res_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_md && !w_div0) begin
                        state_d  = S_BUSY;
                        cnt_d    = CNTW'(WIDTH);
                        is_div_d = w_is_div;
                        a_d      = w_is_div ? w_mag2 : w_mag1;
                        p_d      = {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                        neg_lo_d = w_s1 ^ w_s2;
                        neg_hi_d = w_s1;
                        zpend_d  = w_zero;
                    end else if (w_div0) begin
                        // Divide by zero resolves immediately without iteration.
                        out_valid_d = 1'b1;
                        res_d       = '1;
                        lo_d        = '1;
                        hi_d        = in1;
                        zero_d      = w_zero;
                    end else begin
                        out_valid_d = 1'b1;
                        res_d       = w_single;
                        zero_d      = w_zero;
                    end
                end
            end
            S_BUSY: begin
                p_d   = w_step;
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    // Last step: result lands in the register so out_valid is seen in DONE.
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    hi_d        = w_fin_hi;
                    lo_d        = w_fin_lo;
                    res_d       = w_fin_lo;
                    zero_d      = zpend_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            a_q         <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            zpend_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            a_q         <= a_d;
            is_div_q    <= is_div_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            zpend_q     <= zpend_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv
// Purpose  : Self-checking bench for alu_muldiv. A driver issues operations
//            and pushes expected results (from a plain-arithmetic reference
//            model of HI/LO and each op) into a queue; a monitor pops and
//            compares on every out_valid, including the cycle it appears.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          out_valid;
    logic [W-1:0]  AluRes;
    logic          zero;
    logic          busy;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .AluRes    (AluRes),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        int           at;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] hi_m     = '0;
    logic [W-1:0] lo_m     = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: updates HI/LO and returns the op result.
    task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output int lat);
        longint       sa, sb_, q, rm;
        logic [63:0]  p;
        logic [4:0]   sh;
        sh  = b[4:0];
        lat = 1;
        r   = '0;
        case (o)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a ^ b;
            4'd4:  r = lo_m;
            4'd5:  r = (a < b) ? 32'd1 : 32'd0;
            4'd6:  r = a - b;
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = a << sh;
            4'd9:  r = a >> sh;
            4'd10: r = $signed(a) >>> sh;
            4'd11, 4'd12: begin
                if (o == 4'd11) begin
                    sa = longint'($signed(a));
                    sb_ = longint'($signed(b));
                    p  = sa * sb_;
                end else begin
                    p = {32'd0, a} * {32'd0, b};
                end
                hi_m = p[63:32];
                lo_m = p[31:0];
                r    = lo_m;
                lat  = W + 1;
            end
            4'd13, 4'd14: begin
                if (b == '0) begin
                    lo_m = '1;
                    hi_m = a;
                end else begin
                    if (o == 4'd13) begin
                        sa = longint'($signed(a));
                        sb_ = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a});
                        sb_ = longint'({32'd0, b});
                    end
                    q    = sa / sb_;
                    rm   = sa % sb_;
                    lo_m = q[31:0];
                    hi_m = rm[31:0];
                    lat  = W + 1;
                end
                r = lo_m;
            end
            default: r = hi_m;
        endcase
    endtask

    // Drive one request (call at a negedge); returns at the negedge after acceptance.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_out);
        int           waited = 0;
        exp_t         e;
        logic [W-1:0] r;
        int           lat;
        in_valid = 1'b1;
        op       = o;
        in1      = a;
        in2      = b;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 (op %0d)", o);
            in_valid = 1'b0;
            return;
        end
        model(o, a, b, r, lat);
        if (expect_out) begin
            e.res = r;
            e.z   = (a == b);
            e.at  = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got AluRes %0h with no pending request", AluRes);
            end else begin
                e = sb.pop_front();
                chk("AluRes", 64'(AluRes), 64'(e.res));
                chk("zero", 64'(zero), 64'(e.z));
                chk("out_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo_cnt;
        int busy_cnt;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;

        reset    = 1'b1;
        in_valid = 1'b0;
        op       = '0;
        in1      = '0;
        in2      = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_AluRes",    64'(AluRes),    64'd0);
        chk("reset_zero",      64'(zero),      64'd0);
        chk("reset_busy",      64'(busy),      64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back single-cycle ops
        issue(4'd2, 32'd5, 32'd7, 1);
        issue(4'd6, 32'd7, 32'd7, 1);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, 1);
        issue(4'd5, 32'hFFFF_FFFF, 32'd1, 1);
        issue(4'd10, 32'h8000_0000, 32'd4, 1);
        issue(4'd8, 32'd1, 32'd31, 1);
        issue(4'd9, 32'h8000_0000, 32'd35, 1);
        idle(2);

        // MULT latency and stall window
        issue(4'd11, 32'hFFFF_FFFE, 32'd3, 1);
        in_valid = 1'b0;
        lo_cnt   = 1;   // the cycle we are in already shows in_ready low
        busy_cnt = busy ? 1 : 0;
        while (!in_ready && lo_cnt < 100) begin
            @(negedge clk);
            if (!in_ready) lo_cnt++;
            if (busy) busy_cnt++;
        end
        chk("mult_in_ready_low_cycles", 64'(lo_cnt), 64'd33);
        chk("mult_busy_cycles", 64'(busy_cnt), 64'd32);
        issue(4'd15, 32'd0, 32'd0, 1);
        issue(4'd4, 32'd0, 32'd0, 1);

        // Divides, held requests while busy
        issue(4'd13, 32'hFFFF_FFF9, 32'd2, 1);
        issue(4'd15, 32'd1, 32'd1, 1);
        issue(4'd14, 32'd100, 32'd7, 1);
        issue(4'd15, 32'd0, 32'd0, 1);
        issue(4'd14, 32'd9, 32'd0, 1);
        issue(4'd15, 32'd0, 32'd0, 1);
        issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(4'd15, 32'd0, 32'd0, 1);
        issue(4'd13, 32'd20, 32'hFFFF_FFFD, 1);
        issue(4'd15, 32'd0, 32'd0, 1);
        issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(4'd15, 32'd0, 32'd0, 1);
        idle(2);

        // Reset in BUSY cycle 10 aborts the operation
        issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        hi_m  = '0;
        lo_m  = '0;
        @(negedge clk);
        chk("reset_busy_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        chk("post_reset_busy", 64'(busy), 64'd0);
        issue(4'd15, 32'd0, 32'd0, 1);
        issue(4'd4, 32'd0, 32'd0, 1);
        idle(40);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(0, 20)); end
                3: rb = ra;
                4: begin ra = -32'($urandom_range(1, 1000)); rb = 32'($urandom_range(1, 50)); end
                default: ;
            endcase
            issue(ro, ra, rb, 1);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        in_valid = 1'b0;

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
